axi_master_port: RTL and testbench

- AXI4 initiator (master) port. It converts a simple local request/stream interface (CPU fetch/LSU or DMA side) into single or INCR-burst AXI read and write transactions.
- It is the counterpart of the slave wrappers on the bus: it drives AW/W/AR, and consumes B/R.
- It has one outstanding transaction at a time and sits between a local engine and the AXI interconnect master slot.

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_master_port.sv | 177 +++++++++++++++++
 tb/tb_axi_master_port.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the local-to-AXI master port: FSM states,
// protocol constants and the response-severity merge.
package axi_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW   = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // The response encodings happen to be ordered by severity, so the worse
   // of two responses is simply the numerically larger one.
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_master_port.sv
// AXI4 master port: turns one local read/write request at a time into a
// single or INCR-burst AXI transaction and reports completion with a response.
module axi_master_port
   import axi_pkg::*;
#(
   parameter int ID_W      = 4,
   parameter int MASTER_ID = 0,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic                wd_valid,
   output logic                wd_ready,
   input  logic [DATA_W-1:0]   wd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_last,
   output logic                done,
   output logic [1:0]          done_resp,
   output logic                busy,
   output logic [ID_W-1:0]     awid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [LEN_W-1:0]    awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [ID_W-1:0]     bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic [ID_W-1:0]     arid,
   output logic [ADDR_W-1:0]   araddr,
   output logic [LEN_W-1:0]    arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,
   input  logic [ID_W-1:0]     rid,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready
);

   localparam logic [ID_W-1:0] MyId = ID_W'(MASTER_ID);

   state_t                state_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [LEN_W-1:0]      len_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic [LEN_W-1:0]      cnt_q;
   logic [1:0]            err_q;
   logic [1:0]            err_d;
   logic                  done_q;
   logic [1:0]            doneResp_q;
   logic                  lastBeat;
   logic                  beatFault;

   assign lastBeat  = (cnt_q == len_q);
   // An ID mismatch or an rlast that disagrees with our own beat count both
   // degrade the response to at least SLVERR.
   assign beatFault = (rid != MyId) || (rlast != lastBeat);
   assign err_d     = worst_resp(err_q,
                        worst_resp(rresp, beatFault ? AXI_RESP_SLVERR : AXI_RESP_OKAY));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         wstrb_q    <= '0;
         cnt_q      <= '0;
         err_q      <= AXI_RESP_OKAY;
         done_q     <= 1'b0;
         doneResp_q <= AXI_RESP_OKAY;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  len_q   <= req_len;
                  wstrb_q <= req_wstrb;
                  cnt_q   <= '0;
                  err_q   <= AXI_RESP_OKAY;
                  state_q <= req_write ? S_AW : S_AR;
               end
            end
            S_AR: if (arready) state_q <= S_R;
            S_AW: if (awready) state_q <= S_W;
            S_W: begin
               if (wd_valid && wready) begin
                  if (lastBeat) begin
                     cnt_q   <= '0;
                     state_q <= S_B;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_B: begin
               if (bvalid) begin
                  doneResp_q <= (bid != MyId) ? AXI_RESP_SLVERR : bresp;
                  done_q     <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            S_R: begin
               // Finish on our own last beat or on rlast, whichever comes
               // first, so a slave that never raises rlast cannot hang us.
               if (rvalid && rd_ready) begin
                  if (lastBeat || rlast) begin
                     doneResp_q <= err_d;
                     done_q     <= 1'b1;
                     cnt_q      <= '0;
                     state_q    <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     err_q <= err_d;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign done_resp = doneResp_q;

   assign awid    = MyId;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = AXI_SIZE_WORD;
   assign awburst = AXI_BURST_INCR;
   assign awvalid = (state_q == S_AW);

   assign arid    = MyId;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = AXI_SIZE_WORD;
   assign arburst = AXI_BURST_INCR;
   assign arvalid = (state_q == S_AR);

   // Write and read data pass straight through while their phase is active.
   assign wvalid   = (state_q == S_W) && wd_valid;
   assign wd_ready = (state_q == S_W) && wready;
   assign wdata    = wd_data;
   assign wstrb    = wstrb_q;
   assign wlast    = (state_q == S_W) && lastBeat;

   assign bready   = (state_q == S_B);

   assign rready   = (state_q == S_R) && rd_ready;
   assign rd_valid = (state_q == S_R) && rvalid;
   assign rd_data  = rdata;
   assign rd_last  = (state_q == S_R) && lastBeat;

endmodule

// File: tb/tb_axi_master_port.sv
// Directed bench for axi_master_port: a table of single-beat read responses
// plus hand-written burst, write, early-rlast and reset sequences.
module tb_axi_master_port;

   logic        clk;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [3:0]  req_wstrb;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic        rd_last, done, busy;
   logic [1:0]  done_resp;
   logic [3:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [3:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [3:0]  vRid;
      logic [1:0]  vResp;
      logic        vLast;
      logic [31:0] vData;
      logic [1:0]  expResp;
   } readVec_t;

   readVec_t vecs [7];

   axi_master_port #(.ID_W(4), .MASTER_ID(0), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_wstrb(req_wstrb),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .done_resp(done_resp), .busy(busy),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present a request and hold it until accepted (bounded).
   task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                input logic [3:0] len, input logic [3:0] strb);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_len   = len;
      req_wstrb = strb;
      #1;
      for (int i = 0; i < 20 && !req_ready; i++) cyc();
      checkOutput("req_ready", req_ready, 1);
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic runTableRead(input int idx);
      applyStimulus(1'b0, 32'h3000_0000 + 32'(idx * 4), 4'd0, 4'hF);
      arready = 1'b1;
      #1 checkOutput("tbl_arvalid", arvalid, 1);
      cyc();
      arready  = 1'b0;
      rvalid   = 1'b1;
      rd_ready = 1'b1;
      rid      = vecs[idx].vRid;
      rresp    = vecs[idx].vResp;
      rlast    = vecs[idx].vLast;
      rdata    = vecs[idx].vData;
      #1 checkOutput("tbl_rd_data", rd_data, vecs[idx].vData);
      cyc();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rid    = 4'd0;
      rresp  = 2'b00;
      #1;
      checkOutput("tbl_done", done, 1);
      checkOutput("tbl_done_resp", done_resp, vecs[idx].expResp);
      cyc();
   endtask

   initial begin
      int k;
      int gap;
      logic hs;

      vecs[0] = '{4'd0, 2'b00, 1'b1, 32'h1111_0000, 2'b00};
      vecs[1] = '{4'd0, 2'b10, 1'b1, 32'h2222_0001, 2'b10};
      vecs[2] = '{4'd0, 2'b11, 1'b1, 32'h3333_0002, 2'b11};
      vecs[3] = '{4'd0, 2'b01, 1'b1, 32'h4444_0003, 2'b01};
      vecs[4] = '{4'd1, 2'b00, 1'b1, 32'h5555_0004, 2'b10};
      vecs[5] = '{4'd0, 2'b00, 1'b0, 32'h6666_0005, 2'b10};
      vecs[6] = '{4'd2, 2'b11, 1'b1, 32'h7777_0006, 2'b11};

      rst = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_wstrb = 0;
      wd_valid = 0; wd_data = 0; rd_ready = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
      rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_done_resp", done_resp, 0);
      checkOutput("rst_valids", {awvalid, arvalid, wvalid, bready, rready}, 0);
      cyc();

      // Single read with a slow arready.
      applyStimulus(1'b0, 32'h1000_0040, 4'd0, 4'hF);
      for (int i = 0; i < 2; i++) begin
         checkOutput("rd1_arvalid", arvalid, 1);
         checkOutput("rd1_araddr", araddr, 32'h1000_0040);
         cyc();
      end
      checkOutput("rd1_arlen", arlen, 0);
      checkOutput("rd1_arpayload", {arid, arsize, arburst}, {4'd0, 3'b010, 2'b01});
      arready = 1'b1;
      cyc();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; rd_ready = 1'b1;
      #1;
      checkOutput("rd1_rd_valid", rd_valid, 1);
      checkOutput("rd1_rd_data", rd_data, 32'hDEAD_BEEF);
      checkOutput("rd1_rd_last", rd_last, 1);
      checkOutput("rd1_rready", rready, 1);
      cyc();
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      checkOutput("rd1_done", done, 1);
      checkOutput("rd1_done_resp", done_resp, 0);
      checkOutput("rd1_busy", busy, 0);
      cyc();
      checkOutput("rd1_done_once", done, 0);

      for (int v = 0; v < 7; v++) runTableRead(v);

      // Four-beat write, wready toggling.
      applyStimulus(1'b1, 32'h2000_0000, 4'd3, 4'hF);
      checkOutput("wr4_awvalid", awvalid, 1);
      checkOutput("wr4_awlen", awlen, 3);
      checkOutput("wr4_awaddr", awaddr, 32'h2000_0000);
      awready = 1'b1;
      cyc();
      awready = 1'b0;
      k = 0;
      for (int c = 0; c < 20 && k < 4; c++) begin
         wd_valid = 1'b1;
         wd_data  = 32'(k + 1);
         wready   = c[0];
         #1;
         checkOutput("wr4_wdata", wdata, 32'(k + 1));
         checkOutput("wr4_wstrb", wstrb, 4'hF);
         hs = wready;
         if (hs) checkOutput("wr4_wlast", wlast, (k == 3) ? 1 : 0);
         cyc();
         if (hs) k++;
      end
      wd_valid = 1'b0;
      wready   = 1'b1;
      checkOutput("wr4_beats", k, 4);
      #1;
      checkOutput("wr4_bready", bready, 1);
      checkOutput("wr4_no_extra_w", {wvalid, wd_ready}, 0);
      bvalid = 1'b1; bid = 4'd0; bresp = 2'b00;
      cyc();
      bvalid = 1'b0; wready = 1'b0;
      #1;
      checkOutput("wr4_done", done, 1);
      checkOutput("wr4_done_resp", done_resp, 0);
      cyc();

      // Eight-beat read with errors on beats 3 and 5 and a back-pressure gap.
      applyStimulus(1'b0, 32'h4000_0000, 4'd7, 4'hF);
      arready = 1'b1;
      cyc();
      arready = 1'b0;
      k = 0;
      gap = 0;
      for (int c = 0; c < 40 && k < 8; c++) begin
         rvalid = 1'b1;
         rdata  = 32'hA000_0000 + 32'(k);
         rresp  = (k == 3) ? 2'b10 : (k == 5) ? 2'b11 : 2'b00;
         rlast  = (k == 7);
         if (k == 4 && gap < 3) begin
            rd_ready = 1'b0;
            gap++;
         end else begin
            rd_ready = 1'b1;
         end
         #1;
         checkOutput("burst_rready", rready, rd_ready);
         hs = rd_ready;
         if (hs) begin
            checkOutput("burst_rd_data", rd_data, 32'hA000_0000 + 32'(k));
            checkOutput("burst_rd_last", rd_last, (k == 7) ? 1 : 0);
         end
         cyc();
         if (hs) k++;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      #1;
      checkOutput("burst_beats", k, 8);
      checkOutput("burst_done", done, 1);
      checkOutput("burst_done_resp", done_resp, 2'b11);
      cyc();

      // Early rlast on beat 2 of a four-beat read, then back-to-back request.
      applyStimulus(1'b0, 32'h5000_0000, 4'd3, 4'hF);
      arready = 1'b1;
      cyc();
      arready = 1'b0;
      rd_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         rvalid = 1'b1;
         rdata  = 32'hB000_0000 + 32'(b);
         rlast  = (b == 1);
         cyc();
      end
      rvalid = 1'b0; rlast = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h6000_0000; req_len = 4'd0;
      #1;
      checkOutput("early_done", done, 1);
      checkOutput("early_done_resp", done_resp, 2'b10);
      checkOutput("early_req_ready", req_ready, 1);
      cyc();
      req_valid = 1'b0;
      #1;
      checkOutput("b2b_arvalid", arvalid, 1);
      checkOutput("b2b_araddr", araddr, 32'h6000_0000);
      arready = 1'b1;
      cyc();
      arready = 1'b0;
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'hC0DE_0001;
      cyc();
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      checkOutput("b2b_done_resp", {done, done_resp}, {1'b1, 2'b00});
      cyc();

      // Single write answered with the wrong bid.
      applyStimulus(1'b1, 32'h7000_0000, 4'd0, 4'h3);
      awready = 1'b1;
      cyc();
      awready = 1'b0;
      wd_valid = 1'b1; wd_data = 32'h0000_00AA; wready = 1'b1;
      #1;
      checkOutput("bid_wlast", wlast, 1);
      checkOutput("bid_wstrb", wstrb, 4'h3);
      cyc();
      wd_valid = 1'b0; wready = 1'b0;
      bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
      cyc();
      bvalid = 1'b0; bid = 4'd0;
      #1;
      checkOutput("bid_done", done, 1);
      checkOutput("bid_done_resp", done_resp, 2'b10);
      cyc();

      // Reset in the middle of a write data phase.
      applyStimulus(1'b1, 32'h8000_0000, 4'd1, 4'hF);
      awready = 1'b1;
      cyc();
      awready = 1'b0;
      wd_valid = 1'b1; wready = 1'b0;
      #1;
      checkOutput("mid_wvalid", wvalid, 1);
      checkOutput("mid_busy", busy, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      wd_valid = 1'b0;
      #1;
      checkOutput("mid_valids", {awvalid, arvalid, wvalid, bready, rready}, 0);
      checkOutput("mid_busy_rst", busy, 0);
      checkOutput("mid_done", done, 0);
      checkOutput("mid_req_ready", req_ready, 1);
      cyc();
      checkOutput("mid_done_after", done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Guard against any unforeseen stall.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
